// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Runtime-programmable serial bit-pattern detector. Shifts in a
//             qualified 1-bit stream, pulses z (Mealy, zero latency) on the
//             bit that completes the programmed pattern, and keeps a
//             saturating count of matches. Supports overlapping and
//             restart-after-match detection.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] c_FILL_MAX = LEN_W'(MAX_LEN);

  // hist[0] is the newest bit; fill counts valid bits held since the last restart
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_nh;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_legal;
  logic               w_fill_ok;
  logic               w_bits_eq;
  logic               w_match;

  assign w_accept  = x_valid & ~clr;
  assign w_nh      = {r_hist[MAX_LEN-2:0], x};
  assign w_legal   = (pat_len != '0) && (pat_len <= c_FILL_MAX);
  // Bits older than the current fill are ignored, so a match needs pat_len bits since restart
  assign w_fill_ok = ((LEN_W+1)'(r_fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(pat_len);
  assign w_bits_eq = ((w_nh ^ pattern) & w_mask) == '0;
  assign w_match   = w_accept & w_legal & w_fill_ok & w_bits_eq;

  assign z         = w_match;
  assign match_cnt = r_cnt;
  assign cnt_sat   = &r_cnt;

  // Select the low pat_len bit positions for the pattern compare
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < pat_len);
    end
  end

  // History, fill level and saturating match counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (x_valid) begin
      r_hist <= w_nh;
      if (w_match && !overlap) begin
        r_fill <= '0;
      end else if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + LEN_W'(1);
      end
      if (w_match && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Self-checking bench for seq_detector_param: table vectors,
//             hand-written corner sequences and randomized stimulus against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;

  logic       clk;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       overlap;
  logic       clr;
  logic       z;
  logic [15:0] match_cnt;
  logic       cnt_sat;
  logic       z2;
  logic [1:0] match_cnt2;
  logic       cnt_sat2;

  int total;
  int bad;

  // reference model state: bits accepted since last restart, oldest first
  bit mq[$];
  int m_cnt16;
  int m_cnt2;

  typedef struct {
    bit x;
    bit exp_z;
  } vec_t;

  vec_t t1[7];
  vec_t t2[7];
  vec_t t4a[8];
  vec_t t4b[4];

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .z(z2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Does the stream (history plus new bit) end in the programmed pattern?
  function automatic bit model_match(input bit xi, input bit vi, input bit ci);
    bit tmp[$];
    int n;
    if (!vi || ci) return 1'b0;
    if (pat_len < 1 || pat_len > MAX_LEN) return 1'b0;
    tmp = mq;
    tmp.push_back(xi);
    n = tmp.size();
    if (n < int'(pat_len)) return 1'b0;
    for (int k = 0; k < int'(pat_len); k++) begin
      if (tmp[n-1-k] != pattern[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  // One clock of stimulus: z checked before the edge, counters after it
  task automatic step(input bit xi, input bit vi, input bit ci, output bit zo);
    bit mm;
    @(negedge clk);
    x = xi; x_valid = vi; clr = ci;
    #1;
    mm = model_match(xi, vi, ci);
    check("z", z, mm);
    check("z_cw2", z2, mm);
    zo = z;
    if (ci) begin
      model_reset();
    end else if (vi) begin
      mq.push_back(xi);
      if (mm && !overlap) mq.delete();
      else if (mq.size() > MAX_LEN) void'(mq.pop_front());
      if (mm) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
    check("match_cnt", match_cnt, m_cnt16);
    check("cnt_sat", cnt_sat, (m_cnt16 == 65535));
    check("match_cnt_cw2", match_cnt2, m_cnt2);
    check("cnt_sat_cw2", cnt_sat2, (m_cnt2 == 3));
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input bit ov);
    bit zd;
    pattern = p; pat_len = l; overlap = ov;
    step(1'b1, 1'b1, 1'b1, zd);
  endtask

  initial begin
    bit zo;
    logic [7:0] s6;
    total = 0; bad = 0;
    reset = 1'b0; x = 1'b0; x_valid = 1'b0; clr = 1'b0;
    pattern = 8'h06; pat_len = 4'd4; overlap = 1'b1;
    model_reset();

    t1 = '{'{0,0}, '{1,0}, '{1,0}, '{0,1}, '{1,0}, '{1,0}, '{0,1}};
    t2 = '{'{0,0}, '{1,0}, '{1,0}, '{0,1}, '{1,0}, '{1,0}, '{0,0}};
    t4a = '{'{1,0}, '{0,0}, '{1,0}, '{0,0}, '{0,0}, '{1,0}, '{0,0}, '{1,1}};
    t4b = '{'{1,1}, '{1,1}, '{0,0}, '{1,1}};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", match_cnt, 16'd0);
    check("reset_sat", cnt_sat, 1'b0);
    check("reset_z", z, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1: overlapping 0110
    configure(8'h06, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(t1[i].x, 1'b1, 1'b0, zo);
      check("t1_z", zo, t1[i].exp_z);
    end
    check("t1_cnt", match_cnt, 16'd2);

    // 2: non-overlapping 0110
    configure(8'h06, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(t2[i].x, 1'b1, 1'b0, zo);
      check("t2_z", zo, t2[i].exp_z);
    end
    check("t2_cnt", match_cnt, 16'd1);

    // 3: case 1 with invalid gaps carrying toggling x
    configure(8'h06, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        step(bit'(g[0] ^ t1[i].x ^ 1'b1), 1'b0, 1'b0, zo);
        check("t3_gap_z", zo, 1'b0);
      end
      step(t1[i].x, 1'b1, 1'b0, zo);
      check("t3_z", zo, t1[i].exp_z);
    end
    check("t3_cnt", match_cnt, 16'd2);

    // 4: full length and single-bit patterns
    configure(8'hA5, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(t4a[i].x, 1'b1, 1'b0, zo);
      check("t4a_z", zo, t4a[i].exp_z);
    end
    configure(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(t4b[i].x, 1'b1, 1'b0, zo);
      check("t4b_z", zo, t4b[i].exp_z);
    end
    check("t4b_cnt", match_cnt, 16'd3);

    // 5: 2-bit counter saturation, then clr drops the concurrent bit
    configure(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, zo);
    check("t5_cnt2", match_cnt2, 2'd3);
    check("t5_sat2", cnt_sat2, 1'b1);
    pattern = 8'h03; pat_len = 4'd2;
    step(1'b1, 1'b1, 1'b1, zo);
    check("t5_clr_z", zo, 1'b0);
    check("t5_clr_cnt2", match_cnt2, 2'd0);
    check("t5_clr_sat2", cnt_sat2, 1'b0);
    step(1'b1, 1'b1, 1'b0, zo);
    check("t5_dropped_bit", zo, 1'b0);
    step(1'b1, 1'b1, 1'b0, zo);
    check("t5_after_clr", zo, 1'b1);

    // 6: async reset mid-pattern discards progress
    configure(8'h06, 4'd4, 1'b1);
    step(1'b0, 1'b1, 1'b0, zo);
    step(1'b1, 1'b1, 1'b0, zo);
    step(1'b1, 1'b1, 1'b0, zo);
    @(negedge clk);
    x_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_rst_cnt", match_cnt, 16'd0);
    check("t6_rst_z", z, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, zo);
    check("t6_no_z", zo, 1'b0);
    s6 = 8'b0000_0110;
    for (int i = 3; i >= 0; i--) begin
      step(s6[i], 1'b1, 1'b0, zo);
      check("t6_z", zo, (i == 0));
    end

    // illegal lengths never match
    for (int l = 9; l < 16; l++) begin
      configure(8'hFF, 4'(l), 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, zo);
    end
    configure(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, zo);
    check("illegal_cnt", match_cnt, 16'd0);

    // randomized configurations and streams against the model
    for (int r = 0; r < 30; r++) begin
      logic [3:0] rl;
      rl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      configure(8'($urandom), rl, bit'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++) begin
        step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 39) == 0), zo);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
